axi_crossbar_skid: RTL and testbench

AXI_CROSSBAR_SKID -- requirements
Module: axi_crossbar_skid

---
 rtl/axi_crossbar_pkg.sv | 18 +
 rtl/axi_crossbar_skid.sv | 146 ++++++++++++++
 tb/tb_axi_crossbar_skid.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/axi_crossbar_pkg.sv
// ============================================================================
// Module      : axi_crossbar_pkg
// Description : Shared types for the axi_crossbar register-slice family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_crossbar_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_crossbar_skid.sv
// ============================================================================
// Module      : axi_crossbar_skid
// Description : Valid/ready skid buffer that registers the ready path.
//               AXI_CROSSBAR_SKID_FWD_REG_EN selects the fully registered slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_crossbar_skid
  import axi_crossbar_pkg::*;
#(
  parameter int DATA_BUS_W = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  i_valid,
  input  logic [DATA_BUS_W-1:0] i_data,
  output logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_BUS_W-1:0] o_data,
  input  logic                  o_ready
);

`ifdef AXI_CROSSBAR_SKID_FWD_REG_EN

  skid_state_e           r_state;
  skid_state_e           w_state_nxt;
  logic                  r_ready;
  logic                  r_out_valid;
  logic [DATA_BUS_W-1:0] r_out_data;
  logic [DATA_BUS_W-1:0] r_skid_data;

  logic                  w_in;
  logic                  w_out;
  logic                  w_load_out;
  logic                  w_load_skid;
  logic                  w_out_from_skid;
  logic                  w_ready_nxt;
  logic                  w_valid_nxt;
  logic [DATA_BUS_W-1:0] w_out_data_nxt;

  assign w_in  = i_valid && r_ready;
  assign w_out = r_out_valid && o_ready;

  // State and every output are registered so neither path is combinational.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= EMPTY;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else if (srst) begin
      r_state     <= EMPTY;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_out_valid <= w_valid_nxt;
      if (w_load_out)  r_out_data  <= w_out_data_nxt;
      if (w_load_skid) r_skid_data <= i_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_in) w_state_nxt = BUSY;
      BUSY: begin
        if (w_in && !w_out)      w_state_nxt = FULL;
        else if (!w_in && w_out) w_state_nxt = EMPTY;
      end
      FULL:    if (w_out) w_state_nxt = BUSY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    case (r_state)
      EMPTY: w_load_out = w_in;
      BUSY: begin
        w_load_skid = w_in && !w_out;
        w_load_out  = w_in && w_out;
      end
      FULL: begin
        w_load_out      = w_out;
        w_out_from_skid = w_out;
      end
      default: ;
    endcase
    w_out_data_nxt = w_out_from_skid ? r_skid_data : i_data;
    w_ready_nxt    = (w_state_nxt != FULL);
    w_valid_nxt    = (w_state_nxt != EMPTY);
  end

  assign i_ready = r_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

`else

  logic                  r_skid_valid;
  logic [DATA_BUS_W-1:0] r_skid_data;
  logic                  r_ready;
  logic                  w_load;
  logic                  w_drain;

  // r_ready set means the skid is empty, so load and drain never coincide.
  assign w_load  = i_valid && r_ready && !o_ready;
  assign w_drain = r_skid_valid && o_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready      <= 1'b1;
    end else if (srst) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready      <= 1'b1;
    end else if (w_load) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
      r_ready      <= 1'b0;
    end else if (w_drain) begin
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end
  end

  assign i_ready = r_ready;
  assign o_valid = i_valid | r_skid_valid;
  assign o_data  = r_skid_valid ? r_skid_data : i_data;

`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_crossbar_skid.sv
// ============================================================================
// Module      : tb_axi_crossbar_skid
// Description : Randomized and directed bench for axi_crossbar_skid against a
//               queue-based reference model of the stored beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_crossbar_skid;

  localparam int DATA_BUS_W = 16;
`ifdef AXI_CROSSBAR_SKID_FWD_REG_EN
  localparam int  CAP     = 2;
  localparam bit  FULL_MD = 1'b1;
`else
  localparam int  CAP     = 1;
  localparam bit  FULL_MD = 1'b0;
`endif

  logic                  aclk;
  logic                  aresetn;
  logic                  srst;
  logic                  i_valid;
  logic [DATA_BUS_W-1:0] i_data;
  logic                  i_ready;
  logic                  o_valid;
  logic [DATA_BUS_W-1:0] o_data;
  logic                  o_ready;

  axi_crossbar_skid #(.DATA_BUS_W(DATA_BUS_W)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // Beats held inside the slice, oldest first.
  logic [DATA_BUS_W-1:0] mq[$];
  logic                  exp_ready;
  logic                  exp_valid;
  logic [DATA_BUS_W-1:0] exp_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_outputs(input logic v, input logic [DATA_BUS_W-1:0] d);
    exp_ready = (mq.size() < CAP);
    if (FULL_MD) begin
      exp_valid = (mq.size() > 0);
      exp_data  = (mq.size() > 0) ? mq[0] : '0;
    end else begin
      exp_valid = (mq.size() > 0) || v;
      exp_data  = (mq.size() > 0) ? mq[0] : d;
    end
  endtask

  // Full slice presents only stored beats; base mode may pass the input through.
  task automatic model_edge(input logic v, input logic [DATA_BUS_W-1:0] d,
                            input logic r, input logic s);
    if (s) begin
      mq.delete();
    end else if (FULL_MD) begin
      if (exp_valid && r) void'(mq.pop_front());
      if (v && exp_ready) mq.push_back(d);
    end else begin
      if (v && exp_ready) mq.push_back(d);
      if (exp_valid && r) void'(mq.pop_front());
    end
  endtask

  task automatic step(input logic v, input logic [DATA_BUS_W-1:0] d,
                      input logic r, input logic s);
    @(negedge aclk);
    i_valid = v;
    i_data  = d;
    o_ready = r;
    srst    = s;
    #1;
    model_outputs(v, d);
    check_val("i_ready", {31'd0, i_ready}, {31'd0, exp_ready});
    check_val("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    if (exp_valid) check_val("o_data", {16'd0, o_data}, {16'd0, exp_data});
    @(posedge aclk);
    model_edge(v, d, r, s);
  endtask

  task automatic send(input logic [DATA_BUS_W-1:0] d, input logic r);
    logic accepted;
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      accepted = (mq.size() < CAP);
      step(1'b1, d, r, 1'b0);
    end
    check_val("send_accept", {31'd0, accepted}, 32'd1);
  endtask

  initial begin
    aresetn = 1'b0;
    srst    = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
    mq.delete();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_val("rst_i_ready", {31'd0, i_ready}, 32'd1);
    check_val("rst_o_valid", {31'd0, o_valid}, 32'd0);
    if (FULL_MD) check_val("rst_o_data", {16'd0, o_data}, 32'd0);
    aresetn = 1'b1;

    // Back-to-back streaming with the sink always ready.
    for (int k = 1; k <= 16; k++) step(1'b1, DATA_BUS_W'(k), 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // Stall: first beat stored, second beat offered while the sink is stopped.
    send(16'hA5A5, 1'b0);
    step(1'b1, 16'h5A5A, 1'b0, 1'b0);
    #1;
    check_val("stall_o_data", {16'd0, o_data}, 32'h0000_A5A5);
    check_val("stall_i_ready", {31'd0, i_ready}, 32'd0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Drain and refill from the stalled state.
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    #1;
    check_val("refill_i_ready", {31'd0, i_ready}, 32'd0);
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    send(16'h1234, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Synchronous reset with beats stored.
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    #1;
    check_val("srst_o_valid", {31'd0, o_valid}, 32'd0);
    check_val("srst_i_ready", {31'd0, i_ready}, 32'd1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    for (int k = 0; k < 10000; k++)
      step(1'($urandom % 2), DATA_BUS_W'($urandom), 1'($urandom % 2),
           1'(($urandom % 64) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
